// File: rtl/fifo_pkg.sv
// fifo_pkg: shared geometry and types for the 512x36 FWFT FIFO
package fifo_pkg;
    localparam int DEPTH = 512;
    localparam int AW = 9;
    localparam int DW = 36;
    localparam int CW = 10;
    typedef logic [AW-1:0] ptr_t;
    typedef logic [DW-1:0] word_t;
    typedef logic [CW-1:0] cnt_t;
endpackage

// File: rtl/fifo36_fwft_if.sv
// fifo36_fwft_if: push/pop handshake and status bundle for fifo36_fwft
interface fifo36_fwft_if;
    import fifo_pkg::*;
    logic wr_en;
    word_t wr_data;
    logic full;
    logic almost_full;
    logic rd_en;
    word_t rd_data;
    logic empty;
    logic almost_empty;
    cnt_t count;
    logic overflow;
    logic underflow;
    modport master (
        output wr_en, wr_data, rd_en,
        input full, almost_full, rd_data, empty, almost_empty, count, overflow, underflow
    );
    modport slave (
        input wr_en, wr_data, rd_en,
        output full, almost_full, rd_data, empty, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fiforam.sv
// fiforam: 512x36 simple dual-port RAM with registered, enable-gated read
module fiforam
    import fifo_pkg::*;
(
    input  logic  clk,
    input  logic  we,
    input  ptr_t  waddr,
    input  word_t wdata,
    input  logic  re,
    input  ptr_t  raddr,
    output word_t rdata
);
    word_t mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/fifo36_fwft.sv
// fifo36_fwft: 512x36 first-word-fall-through FIFO with a two-stage registered read prefetch
module fifo36_fwft
    import fifo_pkg::*;
#(
    parameter int AF_THRESH = 480,
    parameter int AE_THRESH = 16
) (
    input logic clk,
    input logic rst_n,
    fifo36_fwft_if.slave f
);
    ptr_t wr_ptr, rd_ptr;
    cnt_t count, unread;
    word_t ram_q, out_q;
    logic ram_valid, out_valid, ovf, unf;
    logic full, push, pop, xfer, issue;
    assign full = count == cnt_t'(DEPTH);
    assign push = f.wr_en && !full;
    assign pop = f.rd_en && out_valid;
    assign xfer = ram_valid && (!out_valid || pop);
    // count covers prefetched words too, so only words committed on an earlier edge are ever read
    assign unread = count - cnt_t'(ram_valid) - cnt_t'(out_valid);
    assign issue = (unread != '0) && (!ram_valid || xfer);
    fiforam u_ram (
        .clk(clk),
        .we(push),
        .waddr(wr_ptr),
        .wdata(f.wr_data),
        .re(issue),
        .raddr(rd_ptr),
        .rdata(ram_q)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            ram_valid <= 1'b0;
            out_valid <= 1'b0;
            out_q <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            wr_ptr <= push ? wr_ptr + ptr_t'(1) : wr_ptr;
            rd_ptr <= issue ? rd_ptr + ptr_t'(1) : rd_ptr;
            count <= (push && !pop) ? count + cnt_t'(1) : (pop && !push) ? count - cnt_t'(1) : count;
            ram_valid <= issue || (ram_valid && !xfer);
            out_valid <= xfer || (out_valid && !pop);
            out_q <= xfer ? ram_q : out_q;
            ovf <= ovf || (f.wr_en && full);
            unf <= unf || (f.rd_en && !out_valid);
        end
    end
    assign f.full = full;
    assign f.almost_full = count >= cnt_t'(AF_THRESH);
    assign f.almost_empty = count <= cnt_t'(AE_THRESH);
    assign f.empty = !out_valid;
    assign f.rd_data = out_q;
    assign f.count = count;
    assign f.overflow = ovf;
    assign f.underflow = unf;
endmodule

// File: tb/tb_fifo36_fwft.sv
// tb_fifo36_fwft: directed scenario tests for fifo36_fwft with hand-computed expectations
module tb_fifo36_fwft;
    logic clk;
    logic rst_n;
    int checks = 0;
    int passed = 0;
    fifo36_fwft_if f ();
    fifo36_fwft dut (.clk(clk), .rst_n(rst_n), .f(f));
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        f.wr_en = 1'b0;
        f.rd_en = 1'b0;
        f.wr_data = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push_n(input int n, input int base);
        f.wr_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            f.wr_data = 36'(base + i);
            tick();
        end
        f.wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        f.wr_en = 1'b0;
        f.rd_en = 1'b0;
        f.wr_data = '0;
        #2;
        checks++; if (f.empty !== 1'b1) $display("FAIL reset_empty: got %0h want 1", f.empty); else passed++;
        checks++; if (f.full !== 1'b0) $display("FAIL reset_full: got %0h want 0", f.full); else passed++;
        checks++; if (f.almost_full !== 1'b0) $display("FAIL reset_af: got %0h want 0", f.almost_full); else passed++;
        checks++; if (f.almost_empty !== 1'b1) $display("FAIL reset_ae: got %0h want 1", f.almost_empty); else passed++;
        checks++; if (f.count !== 10'd0) $display("FAIL reset_count: got %0d want 0", f.count); else passed++;
        checks++; if (f.rd_data !== 36'h0) $display("FAIL reset_rd_data: got %0h want 0", f.rd_data); else passed++;
        checks++; if (f.overflow !== 1'b0 || f.underflow !== 1'b0) $display("FAIL reset_flags: got %0b%0b want 00", f.overflow, f.underflow); else passed++;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        do_reset();
        f.wr_en = 1'b1;
        f.wr_data = 36'h000000001;
        tick();
        f.wr_en = 1'b0;
        checks++; if (f.empty !== 1'b1) $display("FAIL lat_edge0_empty: got %0h want 1", f.empty); else passed++;
        tick();
        checks++; if (f.empty !== 1'b1) $display("FAIL lat_edge1_empty: got %0h want 1", f.empty); else passed++;
        tick();
        checks++; if (f.empty !== 1'b0) $display("FAIL lat_edge2_empty: got %0h want 0", f.empty); else passed++;
        checks++; if (f.rd_data !== 36'h1) $display("FAIL lat_rd_data: got %0h want 1", f.rd_data); else passed++;
        checks++; if (f.count !== 10'd1) $display("FAIL lat_count: got %0d want 1", f.count); else passed++;
        f.rd_en = 1'b1;
        tick();
        f.rd_en = 1'b0;
        checks++; if (f.empty !== 1'b1 || f.count !== 10'd0) $display("FAIL lat_pop: got empty=%0h count=%0d want 1 0", f.empty, f.count); else passed++;
        checks++; if (f.underflow !== 1'b0) $display("FAIL lat_no_underflow: got %0h want 0", f.underflow); else passed++;
    endtask

    task automatic test_fill();
        do_reset();
        f.wr_en = 1'b1;
        for (int i = 0; i < 512; i++) begin
            f.wr_data = 36'(i);
            tick();
            if (i + 1 == 16 || i + 1 == 17) begin
                checks++; if (f.almost_empty !== (i + 1 == 16)) $display("FAIL fill_ae at %0d: got %0h", i + 1, f.almost_empty); else passed++;
            end
            if (i + 1 == 479 || i + 1 == 480) begin
                checks++; if (f.almost_full !== (i + 1 == 480)) $display("FAIL fill_af at %0d: got %0h", i + 1, f.almost_full); else passed++;
            end
            if (i + 1 == 511) begin
                checks++; if (f.full !== 1'b0) $display("FAIL fill_full_511: got %0h want 0", f.full); else passed++;
            end
        end
        checks++; if (f.full !== 1'b1 || f.count !== 10'd512) $display("FAIL fill_full: got full=%0h count=%0d want 1 512", f.full, f.count); else passed++;
        checks++; if (f.overflow !== 1'b0) $display("FAIL fill_no_overflow: got %0h want 0", f.overflow); else passed++;
        f.wr_data = 36'd999;
        tick();
        f.wr_en = 1'b0;
        checks++; if (f.overflow !== 1'b1) $display("FAIL fill_overflow: got %0h want 1", f.overflow); else passed++;
        checks++; if (f.count !== 10'd512) $display("FAIL fill_ovf_count: got %0d want 512", f.count); else passed++;
        f.rd_en = 1'b1;
        for (int k = 0; k < 512; k++) begin
            checks++; if (f.empty !== 1'b0 || f.rd_data !== 36'(k)) $display("FAIL fill_drain[%0d]: got empty=%0h data=%0h want 0 %0h", k, f.empty, f.rd_data, k); else passed++;
            tick();
        end
        f.rd_en = 1'b0;
        checks++; if (f.empty !== 1'b1 || f.count !== 10'd0) $display("FAIL fill_drained: got empty=%0h count=%0d want 1 0", f.empty, f.count); else passed++;
        checks++; if (f.underflow !== 1'b0) $display("FAIL fill_no_underflow: got %0h want 0", f.underflow); else passed++;
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        do_reset();
        push_n(8, 0);
        tick();
        tick();
        tick();
        checks++; if (f.count !== 10'd8 || f.rd_data !== 36'h0) $display("FAIL b2b_prefill: got count=%0d data=%0h want 8 0", f.count, f.rd_data); else passed++;
        f.wr_en = 1'b1;
        f.rd_en = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            f.wr_data = 36'(8 + n);
            checks++;
            if (f.empty !== 1'b0 || f.rd_data !== 36'(n) || f.count !== 10'd8) begin
                bad++;
                if (bad <= 5) $display("FAIL b2b[%0d]: got empty=%0h data=%0h count=%0d want 0 %0h 8", n, f.empty, f.rd_data, f.count, n);
            end else passed++;
            tick();
        end
        f.wr_en = 1'b0;
        f.rd_en = 1'b0;
        checks++; if (f.count !== 10'd8 || f.rd_data !== 36'd1000) $display("FAIL b2b_end: got count=%0d data=%0h want 8 3e8", f.count, f.rd_data); else passed++;
    endtask

    task automatic test_full_push_pop();
        do_reset();
        push_n(512, 0);
        tick();
        tick();
        f.wr_en = 1'b1;
        f.wr_data = 36'hABC;
        f.rd_en = 1'b1;
        tick();
        f.wr_en = 1'b0;
        checks++; if (f.count !== 10'd511) $display("FAIL fpp_count: got %0d want 511", f.count); else passed++;
        checks++; if (f.overflow !== 1'b1) $display("FAIL fpp_overflow: got %0h want 1", f.overflow); else passed++;
        checks++; if (f.full !== 1'b0) $display("FAIL fpp_full: got %0h want 0", f.full); else passed++;
        for (int k = 1; k < 512; k++) begin
            checks++; if (f.empty !== 1'b0 || f.rd_data !== 36'(k)) $display("FAIL fpp_drain[%0d]: got empty=%0h data=%0h want 0 %0h", k, f.empty, f.rd_data, k); else passed++;
            tick();
        end
        f.rd_en = 1'b0;
        checks++; if (f.empty !== 1'b1 || f.count !== 10'd0) $display("FAIL fpp_drained: got empty=%0h count=%0d want 1 0", f.empty, f.count); else passed++;
    endtask

    task automatic test_underflow();
        do_reset();
        f.wr_en = 1'b1;
        f.wr_data = 36'h5;
        f.rd_en = 1'b1;
        tick();
        f.wr_en = 1'b0;
        f.rd_en = 1'b0;
        checks++; if (f.underflow !== 1'b1) $display("FAIL unf_flag: got %0h want 1", f.underflow); else passed++;
        checks++; if (f.count !== 10'd1) $display("FAIL unf_count: got %0d want 1", f.count); else passed++;
        checks++; if (f.overflow !== 1'b0) $display("FAIL unf_no_overflow: got %0h want 0", f.overflow); else passed++;
        tick();
        tick();
        checks++; if (f.empty !== 1'b0 || f.rd_data !== 36'h5) $display("FAIL unf_data: got empty=%0h data=%0h want 0 5", f.empty, f.rd_data); else passed++;
        tick();
        checks++; if (f.underflow !== 1'b1) $display("FAIL unf_sticky: got %0h want 1", f.underflow); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        f.rd_en = 1'b1;
        tick();
        f.rd_en = 1'b0;
        push_n(100, 1000);
        checks++; if (f.count !== 10'd100 || f.underflow !== 1'b1) $display("FAIL mid_pre: got count=%0d unf=%0h want 100 1", f.count, f.underflow); else passed++;
        f.wr_en = 1'b1;
        f.rd_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (f.empty !== 1'b1 || f.count !== 10'd0) $display("FAIL mid_async: got empty=%0h count=%0d want 1 0", f.empty, f.count); else passed++;
        checks++; if (f.underflow !== 1'b0 || f.overflow !== 1'b0 || f.rd_data !== 36'h0) $display("FAIL mid_flags: got unf=%0h ovf=%0h data=%0h want 0 0 0", f.underflow, f.overflow, f.rd_data); else passed++;
        f.wr_en = 1'b0;
        f.rd_en = 1'b0;
        tick();
        rst_n = 1'b1;
        push_n(3, 7);
        tick();
        tick();
        checks++; if (f.count !== 10'd3 || f.rd_data !== 36'd7) $display("FAIL mid_after: got count=%0d data=%0h want 3 7", f.count, f.rd_data); else passed++;
        f.rd_en = 1'b1;
        tick();
        checks++; if (f.rd_data !== 36'd8) $display("FAIL mid_pop1: got %0h want 8", f.rd_data); else passed++;
        tick();
        checks++; if (f.rd_data !== 36'd9) $display("FAIL mid_pop2: got %0h want 9", f.rd_data); else passed++;
        tick();
        f.rd_en = 1'b0;
        checks++; if (f.empty !== 1'b1 || f.underflow !== 1'b0) $display("FAIL mid_end: got empty=%0h unf=%0h want 1 0", f.empty, f.underflow); else passed++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill();
        test_back_to_back();
        test_full_push_pop();
        test_underflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/fifo36_fwft.md
FIFO36_FWFT -- requirements
Module: fifo36_fwft

Interface
REQ-001 Parameter AF_THRESH, default 480: count at or above which almost_full asserts.
REQ-002 Parameter AE_THRESH, default 16: count at or below which almost_empty asserts.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 wr_en  input  1  push request.
REQ-006 wr_data  input  36  push word.
REQ-007 full  output  1  no push accepted this cycle.
REQ-008 almost_full  output  1  count >= AF_THRESH.
REQ-009 rd_en  input  1  pop request; acknowledges rd_data.
REQ-010 rd_data  output  36  head word, first-word-fall-through, registered.
REQ-011 empty  output  1  rd_data not valid.
REQ-012 almost_empty  output  1  count <= AE_THRESH.
REQ-013 count  output  10  words pushed and not yet popped, 0..512.
REQ-014 overflow  output  1  sticky: push attempted while full.
REQ-015 underflow  output  1  sticky: pop attempted while empty.

Function
REQ-016 Storage SHALL be a 512x36 dual-port RAM: write port at wr_ptr, read port at rd_ptr, one-cycle registered read latency.
REQ-017 A push SHALL be accepted iff wr_en && !full; the word is written at wr_ptr and wr_ptr increments mod 512.
REQ-018 A pop SHALL be accepted iff rd_en && !empty; rd_data advances to the next word on the same edge.
REQ-019 count SHALL increment on push only, decrement on pop only, and stay unchanged on simultaneous push and pop.
REQ-020 full SHALL equal (count == 512); RAM slots free only on pop, not on prefetch.
REQ-021 Read side SHALL be a two-stage prefetch: RAM output stage (ram_valid) feeding output register (out_valid); empty = !out_valid.
REQ-022 The RAM stage SHALL transfer to the output register when ram_valid && (!out_valid || pop).
REQ-023 A RAM read SHALL issue (rd_ptr increments mod 512) when unread words exist and the RAM stage is empty or transferring that cycle.
REQ-024 While ram_valid holds without transfer, the read address SHALL stay stable so the RAM output is preserved.
REQ-025 A read SHALL never target an address written on the same edge; only words committed on a prior edge are readable.
REQ-026 Latency: push sampled at edge k into an empty FIFO SHALL make empty deassert after edge k+2 with rd_data equal to that word.
REQ-027 Sustained pop with data available SHALL yield one word per cycle with no bubbles.
REQ-028 Push when full: word dropped, no state change, overflow set.
REQ-029 Simultaneous push and pop when full: pop accepted, push dropped, overflow set, count becomes 511.
REQ-030 Pop when empty: ignored, underflow set; simultaneous push is accepted normally.
REQ-031 Pointer wrap from 511 to 0 SHALL be seamless; ordering is strict FIFO.
REQ-032 overflow and underflow SHALL clear only by reset.

Reset
REQ-033 rst_n low SHALL asynchronously set wr_ptr=0, rd_ptr=0, count=0, ram_valid=0, out_valid=0, overflow=0, underflow=0.
REQ-034 Reset values: empty=1, full=0, almost_full=0, almost_empty=1, count=0, rd_data=0.
REQ-035 RAM contents SHALL NOT be cleared; reset mid-operation discards all queued words.
REQ-036 Release of rst_n SHALL be followed by normal operation from the next edge.

Structure
REQ-037 Depth (512), address width (9), data width (36) and count width (10) SHALL be constants in a shared package fifo_pkg.
REQ-038 The block SHALL instantiate fiforam as its only sub-module; all pointer, count and prefetch logic is local.

Verification
REQ-039 Reset, push 0x000000001 at edge 0 -> empty deasserts after edge 2, rd_data=0x000000001, count=1.
REQ-040 Push 512 words 0..511 with rd_en=0 -> full=1 at count=512, almost_full from count 480; 513th push sets overflow, count stays 512.
REQ-041 Fill 8, then push and pop every cycle for 1000 cycles -> count stays 8, pops return strict sequence across pointer wrap, no empty bubble.
REQ-042 Full, then simultaneous push 0xABC and pop -> count=511, overflow=1, 0xABC never appears on rd_data.
REQ-043 Empty, rd_en=1 with wr_en=1 data 0x5 -> underflow=1, count=1, rd_data=0x5 two edges later.
REQ-044 rst_n low mid-stream with count=100 -> immediately empty=1, count=0, flags cleared; subsequent push/pop correct from address 0.
